mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port Mini SRC main memory between two requesters:
//  - CPU port: driven by the datapath MAR/MDR with Read/Write from control_unit.
//  - LD port: program loader / DMA that preloads or inspects memory.
//  - Grants alternate round-robin; each access is a multi-cycle req/done transaction.
//  - Sits between the Datapath/loader and the RAM instance, one level under MiniSRC.
// PARAMETERS
//  ADDR_W  9   word-address width (512-word memory)
//  DATA_W  32  data width
//  RD_LAT  1   RAM read latency in cycles (>=1); rdata valid RD_LAT cycles after ram_en
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU access request; held with addr/we/wdata until cpu_done
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  CPU word address (from MAR)
//  cpu_wdata    in   DATA_W  CPU write data (from MDR)
//  cpu_rdata    out  DATA_W  read data, valid while cpu_done=1
//  cpu_done     out  1       one-cycle completion pulse
//  ld_req       in   1       loader request, same rules as cpu_req
//  ld_we        in   1       loader 1=write
//  ld_addr      in   ADDR_W  loader address
//  ld_wdata     in   DATA_W  loader write data
//  ld_rdata     out  DATA_W  loader read data, valid while ld_done=1
//  ld_done      out  1       one-cycle completion pulse
//  ram_en       out  1       RAM access strobe
//  ram_we       out  1       RAM write enable (qualified by ram_en)
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data
//  busy         out  1       1 whenever state != IDLE
//  owner        out  1       current/last grantee: 0=CPU, 1=LD
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; ram_en, ram_we, cpu_done, ld_done, busy = 0;
//   ram_addr, ram_wdata, cpu_rdata, ld_rdata = 0; last grant = LD, so CPU wins the first tie.
//  FSM: IDLE -> ACCESS -> (read: WAIT) -> DONE -> IDLE.
//  - IDLE: if any req, register winner, latch its we/addr/wdata, go to ACCESS.
//    Winner is the sole requester, or on a tie the one NOT granted last.
//  - ACCESS (1 cycle): ram_en=1, ram_we=latched we, ram_addr/wdata=latched.
//    Write -> DONE. Read -> WAIT.
//  - WAIT (RD_LAT cycles, down-counter): on the last WAIT cycle capture ram_rdata
//    into the winner's rdata register, then go to DONE.
//  - DONE (1 cycle): winner's done=1, other done=0; update last grant; -> IDLE.
//  Latency req->done: write 2 cycles; read 2+RD_LAT cycles (RD_LAT=1: 3).
//  Min spacing between grants is 1 IDLE cycle; each requester gets at most one access per round.
//  Requests are sampled only in IDLE. A request present on the DONE cycle is an
//   already-served request; the requester deasserts req or changes its operands on the cycle after done.
//  Request dropped mid-transaction: transaction still completes and done still pulses.
//  Operand changes after grant are ignored (latched in IDLE).
//  The non-granted rdata register holds its last value; rdata is undefined outside done.
//  Reset mid-transaction: immediate abort to IDLE. ram_we falls asynchronously.
//   No done is issued; a write in flight may or may not have reached RAM.
//  Both reqs held continuously: grants alternate CPU, LD, CPU, ...
//  No address range check; ADDR_W bits are passed through unmodified.
// STRUCTURE
//  - Shared header minisrc_defs.vh: state encodings ST_IDLE/ST_ACCESS/ST_WAIT/ST_DONE,
//    owner encodings OWN_CPU/OWN_LD.
//  - Sub-module rr_arb2: 2-way round-robin picker.
//    Ports: req[1:0], last, grant[1:0]. Combinational.
//  - Top level holds the FSM, operand latches, WAIT counter, and rdata registers.
// TESTING
//  1. Reset then cpu_req write addr=0x021 data=0x0000011B -> ram_en&ram_we in cycle 1, cpu_done in cycle 2, busy 1 for cycles 1-2.
//  2. cpu read addr=0x020, RAM holds 0x55, RD_LAT=1 -> cpu_done in cycle 3 with cpu_rdata=0x00000055; ld_done stays 0.
//  3. cpu_req and ld_req together from reset, both held -> grants CPU, LD, CPU, LD; owner toggles; no done pulse overlaps.
//  4. ld write 0xDEADBEEF @0x100 while cpu_req rises during ACCESS -> LD finishes first; CPU granted at next IDLE; memory shows 0xDEADBEEF.
//  5. reset asserted during WAIT of a CPU read -> all outputs 0 at once, no cpu_done; a new read after release completes normally.
//  6. RD_LAT=3, cpu read -> cpu_done exactly 5 cycles after req sampled; captured data = ram_rdata from the 3rd WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the Mini SRC memory-port arbiter:
//   - FSM state encoding (IDLE / ACCESS / WAIT / DONE)
//   - grant-owner encoding (CPU / LD)
//   - default geometry of the 512 x 32 main memory
//   - helper to size the read-latency down-counter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Grant owner; bit position also matches the request/grant vector index.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  // Default memory geometry: 512 words of 32 bits, single-cycle read.
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_LAT_DEF = 1;

  // Width of a counter that must hold values 0 .. lat-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker, purely combinational.
//   A sole requester always wins; on a tie the requester that was NOT granted
//   last wins, so two permanently-asserted requests alternate.
//
// Ports
//   req_i   [1:0]  request vector, bit 0 = CPU, bit 1 = LD
//   last_i         previous grantee (owner_e encoding: 0 = CPU, 1 = LD)
//   grant_o [1:0]  one-hot grant, all zero when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // NOTE: combinational blocks assign every output a default before any
  // branching, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: hand the port to whoever did not have it last time.
      2'b11:   grant_o = (last_i == OWN_LD) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port Mini SRC main memory between the CPU datapath
//   (MAR/MDR) and the program loader / DMA port.  Each access is a
//   multi-cycle req/done transaction sequenced by a small FSM:
//
//     IDLE -> ACCESS -> [WAIT x RD_LAT, reads only] -> DONE -> IDLE
//
//   Requests are sampled only in IDLE; the winner's we/addr/wdata are latched
//   there, so later operand changes or a dropped request do not disturb the
//   transaction in flight.  Latency from the sampling edge to done is 2 cycles
//   for a write and 2+RD_LAT cycles for a read.
//
// Parameters
//   ADDR_W  word-address width            (default 9  -> 512 words)
//   DATA_W  data width                    (default 32)
//   RD_LAT  RAM read latency in cycles    (>= 1)
//
// Ports
//   clk_i                   system clock, all state on the rising edge
//   reset_ni                asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i   CPU request + operands, held until done
//   cpu_rdata_o             CPU read data, valid while cpu_done_o = 1
//   cpu_done_o              one-cycle CPU completion pulse
//   ld_req_i/we_i/addr_i/wdata_i    loader request + operands
//   ld_rdata_o              loader read data, valid while ld_done_o = 1
//   ld_done_o               one-cycle loader completion pulse
//   ram_en_o / ram_we_o     RAM access strobe / write enable (qualified by en)
//   ram_addr_o / ram_wdata_o        RAM address / write data
//   ram_rdata_i             RAM read data, valid RD_LAT cycles after ram_en_o
//   busy_o                  1 whenever the FSM is not in IDLE
//   owner_o                 current / last grantee, 0 = CPU, 1 = LD
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  // CPU port
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,
  // Loader port
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              ld_done_o,
  // RAM port
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  // Status
  output logic              busy_o,
  output logic              owner_o
);

  localparam int unsigned CNT_W = cnt_width(RD_LAT);

  // Value loaded into the WAIT down-counter; zero means "last WAIT cycle".
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;      // current grantee, doubles as "last grant"
  logic                we_q, we_d;            // latched operands of the winner
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;          // remaining WAIT cycles minus one
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

  logic [1:0]          grant;

  // ---------------------------------------------------------------------------
  // Round-robin pick between the two requesters
  // ---------------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .req_i   ({ld_req_i, cpu_req_i}),
    .last_i  (owner_q),
    .grant_o (grant)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // Only IDLE looks at the request lines; the winner's operands are
        // frozen here for the whole transaction.
        if (grant[OWN_LD]) begin
          owner_d = OWN_LD;
          we_d    = ld_we_i;
          addr_d  = ld_addr_i;
          wdata_d = ld_wdata_i;
          state_d = ST_ACCESS;
        end else if (grant[OWN_CPU]) begin
          owner_d = OWN_CPU;
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Read data is valid on exactly this cycle; capture it for the
          // winner only, the other port's register keeps its old contents.
          if (owner_q == OWN_LD) begin
            ld_rdata_d  = ram_rdata_i;
          end else begin
            cpu_rdata_d = ram_rdata_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_LD;        // CPU wins the first tie after reset
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registers, so an asynchronous reset drops
  // ram_en/ram_we and the done pulses immediately.
  // ---------------------------------------------------------------------------
  assign ram_en_o    = (state_q == ST_ACCESS);
  assign ram_we_o    = (state_q == ST_ACCESS) && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

  assign cpu_done_o  = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign ld_done_o   = (state_q == ST_DONE) && (owner_q == OWN_LD);
  assign cpu_rdata_o = cpu_rdata_q;
  assign ld_rdata_o  = ld_rdata_q;

  assign busy_o      = (state_q != ST_IDLE);
  assign owner_o     = owner_q;

endmodule
